// File: rtl/i2c_master_stream.sv
// i2c_master_stream: open-drain I2C master running multi-byte write/read transfers.
// Each bit is four quarters; SCL is released in Q1-Q2 and the quarter timer freezes while SCL is stretched.
module i2c_master_stream #(
  parameter int QUARTER = 125,
  parameter int LEN_W   = 4
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       addr,
  input  logic [LEN_W-1:0] nbytes,
  input  logic [7:0]       tx_data,
  output logic             tx_req,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic             scl_i,
  output logic             scl_oe
);

  // Handshakes: tx_data must be valid in the single cycle tx_req is high (no back-pressure);
  // rx_data is qualified by the one-cycle rx_valid pulse and then held.
  localparam int QW = $clog2(QUARTER);
  localparam logic [QW-1:0] Q_LAST = QW'(QUARTER - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK, S_STOP
  } state_t;

  state_t           state, state_nx;
  logic [QW-1:0]    qcnt;
  logic [1:0]       qtr;
  logic [2:0]       bitn;
  logic [LEN_W-1:0] rem;
  logic [7:0]       shreg;
  logic             rw_r;
  logic             ack_bit;

  logic accept, hold, q_last, bit_end, sample, last_byte;

  assign accept    = (state == S_IDLE) && start && sda_i && scl_i;
  assign hold      = (state != S_IDLE) && !scl_oe && !scl_i;
  assign q_last    = !hold && (qcnt == Q_LAST);
  assign bit_end   = q_last && (qtr == 2'd3);
  assign sample    = q_last && (qtr == 2'd1);
  assign last_byte = (rem == LEN_W'(1));
  assign tx_req    = (state == S_WDATA) && (bitn == 3'd0) && (qtr == 2'd0) && (qcnt == '0);

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state)
      S_START: begin
        sda_oe = 1'b1;
        scl_oe = qtr[1];
      end
      S_ADDR, S_WDATA: begin
        scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
        sda_oe = ~shreg[7];
      end
      S_AACK, S_WACK, S_RDATA: scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
      S_RACK: begin
        scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
        sda_oe = !last_byte;
      end
      S_STOP: begin
        scl_oe = (qtr == 2'd0);
        sda_oe = (qtr != 2'd3);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_START;
      S_START: if (bit_end) state_nx = S_ADDR;
      S_ADDR:  if (bit_end && bitn == 3'd7) state_nx = S_AACK;
      S_AACK: begin
        if (bit_end) begin
          if (ack_bit || rem == '0) state_nx = S_STOP;
          else if (rw_r)            state_nx = S_RDATA;
          else                      state_nx = S_WDATA;
        end
      end
      S_WDATA: if (bit_end && bitn == 3'd7) state_nx = S_WACK;
      S_WACK:  if (bit_end) state_nx = (ack_bit || last_byte) ? S_STOP : S_WDATA;
      S_RDATA: if (bit_end && bitn == 3'd7) state_nx = S_RACK;
      S_RACK:  if (bit_end) state_nx = last_byte ? S_STOP : S_RDATA;
      S_STOP:  if (bit_end) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      qcnt     <= '0;
      qtr      <= 2'd0;
      bitn     <= 3'd0;
      rem      <= '0;
      shreg    <= 8'h00;
      rw_r     <= 1'b0;
      ack_bit  <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
    end else begin
      state    <= state_nx;
      rx_valid <= 1'b0;
      done     <= 1'b0;
      if (state == S_IDLE) begin
        qcnt <= '0;
        qtr  <= 2'd0;
        bitn <= 3'd0;
        if (accept) begin
          busy  <= 1'b1;
          nack  <= 1'b0;
          rw_r  <= rw;
          rem   <= nbytes;
          shreg <= {addr, rw};
        end
      end else begin
        if (!hold) begin
          if (qcnt == Q_LAST) begin
            qcnt <= '0;
            qtr  <= qtr + 2'd1;
          end else begin
            qcnt <= qcnt + QW'(1);
          end
        end
        if (bit_end && (state == S_ADDR || state == S_WDATA || state == S_RDATA))
          bitn <= bitn + 3'd1;
        if (tx_req)
          shreg <= tx_data;
        else if (bit_end && (state == S_ADDR || state == S_WDATA))
          shreg <= {shreg[6:0], 1'b0};
        else if (sample && state == S_RDATA)
          shreg <= {shreg[6:0], sda_i};
        if (sample && (state == S_AACK || state == S_WACK))
          ack_bit <= sda_i;
        // The 8th sample completes the byte; publish it straight from the shifter input.
        if (sample && state == S_RDATA && bitn == 3'd7) begin
          rx_data  <= {shreg[6:0], sda_i};
          rx_valid <= 1'b1;
        end
        if (bit_end) begin
          case (state)
            S_AACK: if (ack_bit) nack <= 1'b1;
            S_WACK: begin
              if (ack_bit) nack <= 1'b1;
              else         rem  <= rem - LEN_W'(1);
            end
            S_RACK: rem <= rem - LEN_W'(1);
            S_STOP: begin
              busy <= 1'b0;
              done <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_stream.sv
// Directed bench for i2c_master_stream: behavioural open-drain slave plus bus monitor,
// with one task per scenario checking hand-computed bit sequences, pulse counts and flags.
module tb_i2c_master_stream;

  localparam int QUARTER = 4;
  localparam int LEN_W   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             rw = 1'b0;
  logic [6:0]       addr = 7'h00;
  logic [LEN_W-1:0] nbytes = '0;
  logic [7:0]       tx_data;
  logic             tx_req, rx_valid, busy, done, nack;
  logic [7:0]       rx_data;
  logic             sda_i, sda_oe, scl_i, scl_oe;

  logic sl_sda_low = 1'b0;
  int   stretch_cnt = 0;
  assign sda_i = ~sda_oe & ~sl_sda_low;
  assign scl_i = ~scl_oe & ~(stretch_cnt > 0);

  i2c_master_stream #(.QUARTER(QUARTER), .LEN_W(LEN_W)) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .nbytes(nbytes),
    .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .done(done), .nack(nack), .sda_i(sda_i), .sda_oe(sda_oe),
    .scl_i(scl_i), .scl_oe(scl_oe)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Slave configuration, set by the scenario tasks.
  logic [7:0] tx_bytes[4];
  logic [7:0] rd_bytes[4];
  int         tx_base = 0;
  int         nack_at = -1;
  bit         stretch_en = 1'b0;

  // Monitor counters and captured traffic.
  int         n_txreq = 0, n_rxv = 0, n_done = 0, n_stop = 0, n_both = 0;
  logic [8:0] got_q[$];
  logic [7:0] rx_q[$];
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic [8:0] mon_acc = '0;
  int         mon_n = 0, sl_bit = 0, sl_byte = 0;
  logic       sl_rw = 1'b0, last_ack = 1'b1;

  assign tx_data = tx_bytes[2'(n_txreq - tx_base)];

  always @(posedge clk) begin
    if (tx_req) n_txreq <= n_txreq + 1;
    if (rx_valid) begin
      n_rxv <= n_rxv + 1;
      rx_q.push_back(rx_data);
    end
    if (done) n_done <= n_done + 1;
    if (done && busy) n_both <= n_both + 1;
    if (stretch_cnt > 0) stretch_cnt <= stretch_cnt - 1;
    prev_scl <= scl_i;
    prev_sda <= sda_i;
    if (prev_scl && scl_i && prev_sda && !sda_i) begin
      mon_n      <= 0;
      sl_bit     <= 0;
      sl_byte    <= 0;
      sl_sda_low <= 1'b0;
    end else if (prev_scl && scl_i && !prev_sda && sda_i) begin
      n_stop     <= n_stop + 1;
      mon_n      <= 0;
      sl_bit     <= 0;
      sl_sda_low <= 1'b0;
    end else if (!prev_scl && scl_i) begin
      if (mon_n == 8) begin
        got_q.push_back({mon_acc[7:0], sda_i});
        mon_n <= 0;
      end else begin
        mon_acc <= {mon_acc[7:0], sda_i};
        mon_n   <= mon_n + 1;
      end
      if (sl_bit == 7 && sl_byte == 0) sl_rw <= sda_i;
      if (sl_bit == 8) last_ack <= sda_i;
      sl_bit <= sl_bit + 1;
    end else if (prev_scl && !scl_i) begin
      if (sl_bit == 8) begin
        sl_sda_low <= (sl_byte == 0 || !sl_rw) ? (sl_byte != nack_at) : 1'b0;
        if (sl_byte == 0 && stretch_en) stretch_cnt <= 1000;
      end else if (sl_bit == 9) begin
        sl_bit     <= 0;
        sl_byte    <= sl_byte + 1;
        sl_sda_low <= (sl_rw && !last_ack) ? !rd_bytes[2'(sl_byte)][7] : 1'b0;
      end else if (sl_rw && sl_byte >= 1 && sl_bit >= 1 && sl_bit <= 7) begin
        sl_sda_low <= !rd_bytes[2'(sl_byte - 1)][3'(7 - sl_bit)];
      end else begin
        sl_sda_low <= 1'b0;
      end
    end
  end

  task automatic run_xfer(input logic r, input logic [6:0] a, input logic [3:0] n,
                          output int cyc, output logic busy_seen, output logic nack_seen,
                          output bit to);
    @(negedge clk);
    start = 1'b1; rw = r; addr = a; nbytes = n;
    @(negedge clk);
    start = 1'b0;
    busy_seen = busy;
    nack_seen = nack;
    cyc = 1;
    to = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (done === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_req, rx_data, rx_valid, busy, done, nack, sda_oe, scl_oe} !== 15'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0",
               {tx_req, rx_data, rx_valid, busy, done, nack, sda_oe, scl_oe});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, sda_oe, scl_oe} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %b required 000", {busy, sda_oe, scl_oe});
    end
  endtask

  task automatic test_write();
    int gb, td, ts, tt, cyc;
    logic bs, ns;
    bit to;
    logic [8:0] exp_q[$];
    logic [8:0] got;
    tx_bytes[0] = 8'h6B; tx_bytes[1] = 8'h00; nack_at = -1;
    gb = got_q.size(); td = n_done; ts = n_stop; tt = n_txreq; tx_base = n_txreq;
    run_xfer(1'b0, 7'h68, 4'd2, cyc, bs, ns, to);
    exp_q = '{9'h1A0, 9'h0D6, 9'h000};
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL write_timeout: no done after %0d cycles", cyc); end
    n_cmp++;
    if (bs !== 1'b1) begin n_bad++; $display("FAIL write_busy: got %b required 1", bs); end
    n_cmp++;
    if (got_q.size() - gb != exp_q.size()) begin
      n_bad++; $display("FAIL write_words: got %0d required %0d", got_q.size() - gb, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (gb + i < got_q.size()) ? got_q[gb + i] : 9'hxxx;
      n_cmp++;
      if (got !== exp_q[i]) begin n_bad++; $display("FAIL write_word%0d: got %h required %h", i, got, exp_q[i]); end
    end
    n_cmp++;
    if (n_txreq - tt != 2) begin n_bad++; $display("FAIL write_txreq: got %0d required 2", n_txreq - tt); end
    n_cmp++;
    if (n_done - td != 1) begin n_bad++; $display("FAIL write_done: got %0d required 1", n_done - td); end
    n_cmp++;
    if (n_stop - ts != 1) begin n_bad++; $display("FAIL write_stop: got %0d required 1", n_stop - ts); end
    n_cmp++;
    if (nack !== 1'b0) begin n_bad++; $display("FAIL write_nack: got %b required 0", nack); end
  endtask

  task automatic test_probe_nack();
    int gb, td, tt, cyc;
    logic bs, ns;
    bit to;
    logic [8:0] got;
    nack_at = 0;
    gb = got_q.size(); td = n_done; tt = n_txreq;
    run_xfer(1'b0, 7'h50, 4'd0, cyc, bs, ns, to);
    nack_at = -1;
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL probe_timeout: no done after %0d cycles", cyc); end
    got = (got_q.size() == gb + 1) ? got_q[gb] : 9'hxxx;
    n_cmp++;
    if (got !== 9'h141) begin n_bad++; $display("FAIL probe_word: got %h required 141", got); end
    n_cmp++;
    if (nack !== 1'b1) begin n_bad++; $display("FAIL probe_nack: got %b required 1", nack); end
    n_cmp++;
    if (n_txreq - tt != 0) begin n_bad++; $display("FAIL probe_txreq: got %0d required 0", n_txreq - tt); end
    n_cmp++;
    if (n_done - td != 1) begin n_bad++; $display("FAIL probe_done: got %0d required 1", n_done - td); end
  endtask

  task automatic test_read();
    int gb, gr, tv, cyc;
    logic bs, ns;
    bit to;
    logic [8:0] exp_q[$];
    logic [7:0] exp_rx[$];
    logic [8:0] got;
    logic [7:0] gotb;
    rd_bytes[0] = 8'hA5; rd_bytes[1] = 8'h3C; rd_bytes[2] = 8'hFF; nack_at = -1;
    gb = got_q.size(); gr = rx_q.size(); tv = n_rxv;
    run_xfer(1'b1, 7'h68, 4'd3, cyc, bs, ns, to);
    exp_q = '{9'h1A2, 9'h14A, 9'h078, 9'h1FF};
    exp_rx = '{8'hA5, 8'h3C, 8'hFF};
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL read_timeout: no done after %0d cycles", cyc); end
    n_cmp++;
    if (ns !== 1'b0) begin n_bad++; $display("FAIL read_nack_cleared: got %b required 0", ns); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (gb + i < got_q.size()) ? got_q[gb + i] : 9'hxxx;
      n_cmp++;
      if (got !== exp_q[i]) begin n_bad++; $display("FAIL read_word%0d: got %h required %h", i, got, exp_q[i]); end
    end
    n_cmp++;
    if (n_rxv - tv != 3) begin n_bad++; $display("FAIL read_rxvalid: got %0d required 3", n_rxv - tv); end
    for (int i = 0; i < exp_rx.size(); i++) begin
      gotb = (gr + i < rx_q.size()) ? rx_q[gr + i] : 8'hxx;
      n_cmp++;
      if (gotb !== exp_rx[i]) begin n_bad++; $display("FAIL read_rx%0d: got %h required %h", i, gotb, exp_rx[i]); end
    end
    n_cmp++;
    if (rx_data !== 8'hFF) begin n_bad++; $display("FAIL read_rx_hold: got %h required ff", rx_data); end
    n_cmp++;
    if (nack !== 1'b0) begin n_bad++; $display("FAIL read_nack: got %b required 0", nack); end
  endtask

  task automatic test_stretch();
    int gb, c0, c1;
    logic bs, ns;
    bit to0, to1;
    logic [8:0] got0, got1;
    tx_bytes[0] = 8'h5A; nack_at = -1;
    tx_base = n_txreq;
    run_xfer(1'b0, 7'h68, 4'd1, c0, bs, ns, to0);
    stretch_en = 1'b1;
    gb = got_q.size(); tx_base = n_txreq;
    run_xfer(1'b0, 7'h68, 4'd1, c1, bs, ns, to1);
    stretch_en = 1'b0;
    n_cmp++;
    if (to0 || to1) begin n_bad++; $display("FAIL stretch_timeout: got %b%b required 00", to0, to1); end
    got0 = (gb < got_q.size()) ? got_q[gb] : 9'hxxx;
    got1 = (gb + 1 < got_q.size()) ? got_q[gb + 1] : 9'hxxx;
    n_cmp++;
    if (got0 !== 9'h1A0) begin n_bad++; $display("FAIL stretch_addr: got %h required 1a0", got0); end
    n_cmp++;
    if (got1 !== 9'h0B4) begin n_bad++; $display("FAIL stretch_data: got %h required 0b4", got1); end
    // The 1000-cycle hold overlaps the SCL-low time the master already spends around the ACK bit.
    n_cmp++;
    if (c1 - c0 < 1000 - 3 * QUARTER || c1 - c0 > 1000) begin
      n_bad++; $display("FAIL stretch_extension: got %0d cycles required %0d..1000", c1 - c0, 1000 - 3 * QUARTER);
    end
  endtask

  task automatic test_write_nack();
    int gb, td, tt, cyc;
    logic bs, ns;
    bit to;
    logic [8:0] exp_q[$];
    logic [8:0] got;
    tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22; tx_bytes[2] = 8'h33; nack_at = 2;
    gb = got_q.size(); td = n_done; tt = n_txreq; tx_base = n_txreq;
    run_xfer(1'b0, 7'h3A, 4'd3, cyc, bs, ns, to);
    nack_at = -1;
    exp_q = '{9'h0E8, 9'h022, 9'h045};
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL wnack_timeout: no done after %0d cycles", cyc); end
    n_cmp++;
    if (got_q.size() - gb != 3) begin n_bad++; $display("FAIL wnack_words: got %0d required 3", got_q.size() - gb); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (gb + i < got_q.size()) ? got_q[gb + i] : 9'hxxx;
      n_cmp++;
      if (got !== exp_q[i]) begin n_bad++; $display("FAIL wnack_word%0d: got %h required %h", i, got, exp_q[i]); end
    end
    n_cmp++;
    if (n_txreq - tt != 2) begin n_bad++; $display("FAIL wnack_txreq: got %0d required 2", n_txreq - tt); end
    n_cmp++;
    if (nack !== 1'b1) begin n_bad++; $display("FAIL wnack_nack: got %b required 1", nack); end
    n_cmp++;
    if (n_done - td != 1) begin n_bad++; $display("FAIL wnack_done: got %0d required 1", n_done - td); end
  endtask

  task automatic test_busy_start();
    int gb, td;
    bit to;
    logic [8:0] got;
    nack_at = -1;
    gb = got_q.size(); td = n_done;
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 7'h22; nbytes = 4'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; rw = 1'b1; addr = 7'h55; nbytes = 4'd3;
    @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (done === 1'b1) begin to = 1'b0; break; end
      @(negedge clk);
    end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (to) begin n_bad++; $display("FAIL busy_timeout: no done seen"); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_second_xfer: busy %b required 0", busy); end
    n_cmp++;
    if (n_done - td != 1) begin n_bad++; $display("FAIL busy_done: got %0d required 1", n_done - td); end
    got = (got_q.size() == gb + 1) ? got_q[gb] : 9'hxxx;
    n_cmp++;
    if (got !== 9'h088) begin n_bad++; $display("FAIL busy_word: got %h required 088", got); end
  endtask

  task automatic test_reset_mid();
    int gb, td, cyc;
    logic bs, ns;
    bit to;
    logic [8:0] got;
    tx_bytes[0] = 8'h99; tx_bytes[1] = 8'h66; tx_base = n_txreq; nack_at = -1;
    td = n_done;
    @(negedge clk);
    start = 1'b1; rw = 1'b0; addr = 7'h7F; nbytes = 4'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b required 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({sda_oe, scl_oe, busy, done} !== 4'b0000) begin
      n_bad++; $display("FAIL rstmid_released: got %b required 0000", {sda_oe, scl_oe, busy, done});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (n_done - td != 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d required 0", n_done - td); end
    gb = got_q.size();
    run_xfer(1'b0, 7'h22, 4'd0, cyc, bs, ns, to);
    got = (got_q.size() == gb + 1) ? got_q[gb] : 9'hxxx;
    n_cmp++;
    if (to || got !== 9'h088) begin
      n_bad++; $display("FAIL rstmid_recover: timeout %b word %h required 088", to, got);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_probe_nack();
    test_read();
    test_stretch();
    test_write_nack();
    test_busy_start();
    test_reset_mid();
    n_cmp++;
    if (n_both != 0) begin n_bad++; $display("FAIL done_busy_overlap: got %0d cycles required 0", n_both); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_stream.md
Name: i2c_master_stream

Overview:
Second-generation I2C master. Runs multi-byte write and read transfers with a run-time byte count, using open-drain SCL/SDA. Supports clock stretching, ACK/NACK detection and master ACK/NACK on reads. Sits between a control FSM (register/sensor sequencer) and the board I2C pins, on the CLOCK_50 domain.

Parameters:
QUARTER, 125, CLOCK_50 cycles per quarter bit period (125 gives 100 kHz at 50 MHz); must be 2 or more.
LEN_W, 4, width of the byte-count input; maximum transfer is 2^LEN_W-1 bytes.

Ports:
CLOCK_50  in  1  system clock
rst_n  in  1  synchronous reset, active low
start  in  1  request a transfer; sampled only in IDLE
rw  in  1  0 = write, 1 = read; latched on accept
addr  in  7  7-bit slave address; latched on accept
nbytes  in  LEN_W  data byte count; latched on accept; 0 = address-only probe
tx_data  in  8  write byte, sampled in the cycle tx_req is high
tx_req  out  1  1-cycle pulse: tx_data consumed, present the next byte
rx_data  out  8  last received byte; held until the next byte arrives
rx_valid  out  1  1-cycle pulse: rx_data updated
busy  out  1  high from accept until the cycle done pulses
done  out  1  1-cycle pulse at the end of a transfer
nack  out  1  sticky error flag; cleared on the next accepted start
sda_i  in  1  SDA pin level
sda_oe  out  1  1 = pull SDA low, 0 = release
scl_i  in  1  SCL pin level
scl_oe  out  1  1 = pull SCL low, 0 = release

Behaviour:
- Reset (rst_n=0 at a CLOCK_50 edge): all outputs 0, rx_data=0, state IDLE, counters 0. Reset mid-transfer releases both lines on that edge; no STOP is generated.
- Bit timing: each bit is 4 quarters of QUARTER cycles each.
  - Q0: SCL low; SDA changes only here.
  - Q1 and Q2: SCL released.
  - Q3: SCL low.
  - SDA is sampled on the last cycle of Q1.
- Clock stretching: after releasing SCL, the quarter counter holds until scl_i=1.
- Accept: start=1 in IDLE with sda_i=1 and scl_i=1 (bus free). Latch addr, rw, nbytes; clear nack; busy=1 from the next cycle. start while busy or with the bus not free is ignored.
- States:
  - IDLE
  - START: SDA falls while SCL is high, half a bit, then SCL low.
  - ADDR: 8 bits {addr,rw}, MSB first.
  - AACK: SDA released, sampled.
  - WDATA / WACK
  - RDATA / RACK
  - STOP: SDA low, SCL released, then SDA released while SCL is high; one bit time.
  - IDLE
- AACK result:
  - Slave drives 0 (ACK) and nbytes=0: go to STOP.
  - ACK with rw=0: go to WDATA.
  - ACK with rw=1: go to RDATA.
  - Slave leaves 1 (NACK): nack=1, then STOP.
- Write:
  - tx_req pulses in the first cycle of each WDATA byte, and tx_data is latched in that cycle.
  - After WACK: NACK sets nack=1 and goes to STOP. ACK decrements the remaining count; at 0 go to STOP, else WDATA.
- Read:
  - SDA is released during the 8 RDATA bits, shifted MSB first.
  - rx_data/rx_valid update one cycle after the 8th sample.
  - In RACK the master drives SDA low (ACK) for every byte but the last; for the last byte it releases SDA (NACK).
- done pulses in the cycle after STOP completes; busy falls in that same cycle, and done and busy are never both high.
- Byte counter: LEN_W bits, no wrap; nbytes=2^LEN_W-1 is legal.
- sda_oe and scl_oe never drive high; the bus is open-drain only.

Test Plan:
- Write addr=0x68, rw=0, nbytes=2, tx bytes 0x6B then 0x00, slave ACKs all -> SDA bit sequence 0xD0, A, 0x6B, A, 0x00, A, then STOP; tx_req pulses exactly 2 times; done=1 once; nack=0.
- Probe addr=0x50, nbytes=0, slave NACKs the address -> STOP right after AACK; nack=1; done pulse; no tx_req.
- Read addr=0x68, rw=1, nbytes=3, slave returns 0xA5, 0x3C, 0xFF -> rx_valid pulses 3 times with those values; master ACK, ACK, NACK; then STOP.
- Clock stretch: slave holds scl_i low for 1000 cycles during the ACK bit of the address -> quarter counter frozen; transfer completes with correct data; total time extended by 1000 cycles.
- Write nbytes=3 with the slave NACKing the 2nd data byte -> STOP after the 2nd WACK; nack=1; tx_req count is 2.
- Assert rst_n=0 mid-ADDR; also pulse start while busy -> after reset sda_oe=scl_oe=busy=0 on the next edge; the start pulse while busy is ignored (single transfer observed).
